// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, opcodes and fetch-stage state.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_FULL  = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: sequential, branch, register jump and absolute jump.
module next_pc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] rs_data,
    input  logic [31:0] imm_ext,
    input  logic [25:0] j_index,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] br_target;

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + (imm_ext << 2);
    assign misalign  = (pc_src == PCSRC_JR) && (rs_data[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = br_target;
            PCSRC_JR:  next_pc = {rs_data[31:2], 2'b00};
            PCSRC_J:   next_pc = {pc_plus4[31:28], j_index, 2'b00};
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, one-entry instruction fetch buffer and instruction register for the multicycle CPU.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic [31:0] rs_data,
    input  logic [31:0] imm_ext,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        ir_valid,
    output logic        fetch_stall,
    output logic        misalign
);

    fetch_state_t state, state_nxt;
    logic [31:0]  req_addr, req_addr_nxt;
    logic [31:0]  fbuf;
    logic [31:0]  next_pc;
    logic         jr_misalign;
    logic         pending, pending_nxt;
    logic         buf_load, ir_from_buf, ir_from_mem;

    next_pc_mux u_next_pc_mux (
        .pc       (pc),
        .pc_src   (PCSrc),
        .rs_data  (rs_data),
        .imm_ext  (imm_ext),
        .j_index  (instr[25:0]),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc),
        .misalign (jr_misalign)
    );

    assign imem_req    = (state == FS_FETCH) || (state == FS_FLUSH);
    assign imem_addr   = req_addr;
    assign opcode      = instr[31:26];
    assign fetch_stall = pending || (IRWre && (state == FS_FETCH) && !imem_ready);

    always_comb begin
        state_nxt    = state;
        req_addr_nxt = req_addr;
        pending_nxt  = pending;
        buf_load     = 1'b0;
        ir_from_buf  = 1'b0;
        ir_from_mem  = 1'b0;
        case (state)
            FS_FETCH: begin
                if (PCWre) begin
                    // A PC change makes the in-flight word stale; a same-cycle return is simply dropped.
                    pending_nxt = 1'b0;
                    if (imem_ready) begin
                        req_addr_nxt = next_pc;
                    end else begin
                        state_nxt = FS_FLUSH;
                    end
                end else if (imem_ready) begin
                    buf_load  = 1'b1;
                    state_nxt = FS_FULL;
                    if (pending || IRWre) begin
                        ir_from_mem = 1'b1;
                        pending_nxt = 1'b0;
                    end
                end else if (IRWre) begin
                    pending_nxt = 1'b1;
                end
            end
            FS_FULL: begin
                ir_from_buf = IRWre;
                if (PCWre) begin
                    req_addr_nxt = next_pc;
                    state_nxt    = FS_FETCH;
                end
            end
            FS_FLUSH: begin
                if (imem_ready) begin
                    req_addr_nxt = PCWre ? next_pc : pc;
                    state_nxt    = FS_FETCH;
                end
            end
            default: state_nxt = FS_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= FS_FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            instr    <= 32'h0;
            ir_valid <= 1'b0;
            pending  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_addr <= req_addr_nxt;
            pending  <= pending_nxt;
            misalign <= PCWre && jr_misalign;
            if (PCWre) begin
                pc <= next_pc;
            end
            if (ir_from_buf) begin
                instr <= fbuf;
            end else if (ir_from_mem) begin
                instr <= imem_rdata;
            end
            if (PCWre) begin
                ir_valid <= 1'b0;
            end else if (ir_from_buf || ir_from_mem) begin
                ir_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            fbuf <= imem_rdata;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the multicycle CPU, directly upstream of the control unit. Holds the PC, fetches instructions from a handshaked instruction memory into a one-entry fetch buffer, and loads the instruction register (IR) on `IRWre`. It computes the next PC from the control unit's `PCWre`/`PCSrc` and supplies `opcode` and `pc_plus4` (for `jal` write-back).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `clk`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `PCWre`  in  1: advance PC to the next-PC value at this edge.
- `PCSrc`  in  2: next-PC select. 00 = PC+4, 01 = branch, 10 = jr, 11 = j/jal.
- `IRWre`  in  1: load IR from the fetch buffer.
- `rs_data`  in  32: register rs value, used as the `jr` target.
- `imm_ext`  in  32: sign-extended 16-bit immediate, used as the branch offset.
- `imem_req`  out  1: instruction-memory request.
- `imem_addr`  out  32: request address; stable while `imem_req` is high.
- `imem_ready`  in  1: memory returns `imem_rdata` this cycle; consumes the request.
- `imem_rdata`  in  32: fetched word.
- `pc`  out  32: current PC.
- `pc_plus4`  out  32: `pc`+4.
- `instr`  out  32: IR contents.
- `opcode`  out  6: `instr[31:26]`.
- `ir_valid`  out  1: IR holds the instruction at `pc`.
- `fetch_stall`  out  1: `IRWre` seen but no data yet; IR load is pending.
- `misalign`  out  1: one-cycle pulse when a jr target had nonzero low bits.

## Operation
- FSM states:
  - FETCH: request outstanding for the current `pc`.
  - FULL: buffer holds the word for `pc`.
  - FLUSH: request outstanding for a stale PC; its data will be dropped.
- `imem_req` = (state is FETCH or FLUSH). `imem_addr` is driven from a registered `req_addr`.
- Transitions:
  - FETCH + `imem_ready`: buffer <= `imem_rdata`, go to FULL.
  - FETCH + `PCWre` (no ready): go to FLUSH.
  - FETCH + `PCWre` + `imem_ready` in the same cycle: drop the data, go to FETCH at the new PC.
  - FULL + `PCWre`: invalidate the buffer, `req_addr` <= next PC, go to FETCH.
  - FLUSH + `imem_ready`: drop the data, `req_addr` <= `pc`, go to FETCH.
  - FLUSH + `PCWre`: update `pc` and stay in FLUSH.
- IR load:
  - `IRWre` in FULL: IR <= buffer, `ir_valid` = 1.
  - `IRWre` in FETCH: set `pending`. On the next `imem_ready` in FETCH, IR and the buffer both load `imem_rdata`, and `pending` clears.
  - `IRWre` and `PCWre` in the same FULL cycle: IR gets the old buffer word, then the PC advances (prefetch).
- `PCWre` clears `ir_valid` and `pending`.
- Next-PC arithmetic is modulo 2^32:
  - branch = `pc_plus4` + (`imm_ext` << 2).
  - jr = `rs_data` with bits [1:0] forced to 00; `misalign` = |`rs_data[1:0]`.
  - j/jal = {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}. This uses the IR, not the buffer.
  - 32'hFFFF_FFFC + 4 wraps to 0.
- Any `PCSrc` value outside 00..11 (X or Z in simulation) selects PC+4 through the default arm.
- `PCWre` = 0 holds `pc`, regardless of `PCSrc`.

## Timing
- Reset values: `pc`=RESET_PC, `pc_plus4`=RESET_PC+4, `instr`=0, `opcode`=0, `ir_valid`=0, `fetch_stall`=0, `misalign`=0, state FETCH.
- In the cycle after reset is released, `imem_req`=1 and `imem_addr`=RESET_PC.
- Asserting `RST` mid-fetch abandons the request. The memory shares `RST` and drops it too.
- Minimum fetch latency is 1 cycle: with `imem_ready` in the first FETCH cycle, FULL follows at the next edge.
- IR latency:
  - From FULL, `instr` updates at the edge where `IRWre`=1.
  - From FETCH, `instr` updates at the edge where `imem_ready`=1.
- `fetch_stall` = `pending` | (`IRWre` & state==FETCH & !`imem_ready`). It is combinational.
- `pc` updates at the edge where `PCWre`=1. The next-PC inputs are sampled at that edge.

## Structure
- Shared package `cpu_pkg` holds:
  - PCSrc encodings: `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_JR`, `PCSRC_J`.
  - Opcode constants.
  - Fetch state enum: `FS_FETCH`, `FS_FULL`, `FS_FLUSH`.
- Sub-module: `next_pc_mux`, purely combinational, containing the adders, alignment and `misalign` logic.

## Test plan
- Reset with RESET_PC=0x40, `imem_ready` tied to 1, mem[0x40]=0x0000_1234, `IRWre` pulsed → `imem_addr`=0x40, then `instr`=0x0000_1234, `ir_valid`=1, `pc_plus4`=0x44.
- `PCSrc`=01, `imm_ext`=0xFFFF_FFFE, `PCWre`=1 at `pc`=0x10 → `pc`=0x0C. Then `PCSrc`=11 with `instr[25:0]`=0x100 → `pc`=0x400.
- `jr` with `rs_data`=0x1003 → `pc`=0x1000 and a one-cycle `misalign` pulse. With `pc`=0xFFFF_FFFC and `PCSrc`=00 → `pc`=0.
- `imem_ready` delayed 3 cycles, `IRWre` in the first FETCH cycle → `fetch_stall`=1 for 3 cycles, then `instr` loads on the ready edge.
- `PCWre` to 0x80 while a request to 0x20 is outstanding → `imem_addr` holds 0x20 until ready, that data is dropped, then `imem_addr`=0x80. `instr` never takes the 0x20 word.
- `RST` in a FULL cycle with `IRWre`=1 → `instr`=0 and `pc`=RESET_PC next cycle.
